// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: state encoding and field widths.
package boot_pkg;

  localparam int LEN_W   = 16;
  localparam int CKSUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic is_rx_state(input boot_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte stream in, program memory write port out.
// Handshake: a stream byte transfers on a cycle where rx_valid && rx_ready are
// both high at the rising clk edge; rx_data must be stable while rx_valid is
// high, and rx_ready depends only on loader state (never on rx_valid).
// The write port is a bare strobe: prog_addr/prog_wdata are valid when prog_we=1.
interface boot_loader_if #(
  parameter int PROG_AW = 12
) ();
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               prog_we;
  logic [PROG_AW-1:0] prog_addr;
  logic [7:0]         prog_wdata;

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, prog_we, prog_addr, prog_wdata
  );

  // Stream source / memory side.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, prog_we, prog_addr, prog_wdata
  );
endinterface

// File: rtl/boot_watchdog.sv
// Idle-cycle counter; expired flags when the count reaches TIMEOUT_CYCLES.
module boot_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic clk,
  input  logic arst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  assign expired = (cnt == TO_W'(TIMEOUT_CYCLES));

  // Count idle cycles; clear wins, and the count holds once expired.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, checksummed image from a byte stream into program
// memory, holding the CPU in reset until the image verifies.
module boot_loader
  import boot_pkg::*;
#(
  parameter int PROG_AW        = 12,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20,
  parameter bit AUTO_BOOT      = 1'b1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        boot_req,
  boot_loader_if.slave bus,
  output logic        bootstrapping,
  output logic        cpu_rst_n,
  output logic        boot_done,
  output logic        boot_error,
  output boot_state_e dbg_state
);

  localparam boot_state_e RST_STATE = AUTO_BOOT ? ST_LEN_HI : ST_IDLE;
  localparam logic [LEN_W:0] CAP    = {{LEN_W{1'b0}}, 1'b1} << PROG_AW;

  boot_state_e        state;
  logic [7:0]         len_hi;
  logic [LEN_W-1:0]   remaining;
  logic [CKSUM_W-1:0] cksum;
  logic               armed;   // LEN_HI may time out only after an explicit boot_req
  logic               prog_we;
  logic [PROG_AW-1:0] prog_addr;
  logic [7:0]         prog_wdata;

  logic               rx_ready;
  logic               accept;
  logic [LEN_W-1:0]   len_full;
  logic               wd_active;
  logic               wd_expired;

  assign rx_ready       = is_rx_state(state);
  assign accept         = bus.rx_valid && rx_ready;
  assign len_full       = {len_hi, bus.rx_data};
  assign wd_active      = rx_ready && !((state == ST_LEN_HI) && !armed);
  assign bus.rx_ready   = rx_ready;
  assign bus.prog_we    = prog_we;
  assign bus.prog_addr  = prog_addr;
  assign bus.prog_wdata = prog_wdata;
  assign dbg_state      = state;

  boot_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .arst_n (arst_n),
    .enable (wd_active),
    .clear  (accept || !wd_active),
    .expired(wd_expired)
  );

  // Load FSM with all outputs registered; an accepted byte takes priority over a timeout.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= RST_STATE;
      len_hi        <= '0;
      remaining     <= '0;
      cksum         <= '0;
      armed         <= 1'b0;
      prog_we       <= 1'b0;
      prog_addr     <= '0;
      prog_wdata    <= '0;
      boot_done     <= 1'b0;
      boot_error    <= 1'b0;
      cpu_rst_n     <= !AUTO_BOOT;
      bootstrapping <= AUTO_BOOT;
    end else begin
      prog_we <= 1'b0;
      // Address advances once the write strobe has been presented.
      if (prog_we) prog_addr <= prog_addr + 1'b1;

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (boot_req) begin
            state         <= ST_LEN_HI;
            boot_done     <= 1'b0;
            boot_error    <= 1'b0;
            cksum         <= '0;
            prog_addr     <= '0;
            cpu_rst_n     <= 1'b0;
            bootstrapping <= 1'b1;
            armed         <= 1'b1;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi <= bus.rx_data;
            state  <= ST_LEN_LO;
          end else if (wd_expired) begin
            state         <= ST_ERROR;
            boot_error    <= 1'b1;
            bootstrapping <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            if ((len_full == '0) || ({1'b0, len_full} > CAP)) begin
              state         <= ST_ERROR;
              boot_error    <= 1'b1;
              bootstrapping <= 1'b0;
            end else begin
              remaining <= len_full;
              state     <= ST_DATA;
            end
          end else if (wd_expired) begin
            state         <= ST_ERROR;
            boot_error    <= 1'b1;
            bootstrapping <= 1'b0;
          end
        end
        ST_DATA: begin
          if (accept) begin
            prog_wdata <= bus.rx_data;
            prog_we    <= 1'b1;
            cksum      <= cksum + bus.rx_data;
            remaining  <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= ST_CHECK;
          end else if (wd_expired) begin
            state         <= ST_ERROR;
            boot_error    <= 1'b1;
            bootstrapping <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            bootstrapping <= 1'b0;
            if (bus.rx_data == cksum) begin
              state     <= ST_DONE;
              boot_done <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state      <= ST_ERROR;
              boot_error <= 1'b1;
            end
          end else if (wd_expired) begin
            state         <= ST_ERROR;
            boot_error    <= 1'b1;
            bootstrapping <= 1'b0;
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: writes are scored against an expected queue.
module tb_boot_loader;
  import boot_pkg::*;

  localparam int AW = 12;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        boot_req = 1'b0;
  logic        bootstrapping, cpu_rst_n, boot_done, boot_error;
  boot_state_e dbg_state;

  boot_loader_if #(.PROG_AW(AW)) bus ();

  boot_loader #(
    .PROG_AW(AW), .TIMEOUT_CYCLES(TO), .TO_W(20), .AUTO_BOOT(1'b1)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .boot_req     (boot_req),
    .bus          (bus.slave),
    .bootstrapping(bootstrapping),
    .cpu_rst_n    (cpu_rst_n),
    .boot_done    (boot_done),
    .boot_error   (boot_error),
    .dbg_state    (dbg_state)
  );

  // Clock and run-time guard.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1, "simulation time limit");
  end

  int              total = 0;
  int              bad = 0;
  int              n_writes = 0;
  logic [AW+7:0]   exp_q[$];
  logic [7:0]      pl[$];
  logic [AW-1:0]   exp_addr = '0;
  logic [7:0]      sum = '0;
  logic            we_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pay);
    int n;
    @(negedge clk);
    boot_req     = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    if (pay) begin
      exp_q.push_back({exp_addr, b});
      exp_addr = exp_addr + 1'b1;
      sum      = sum + b;
      #1 we_exp = 1'b1;
    end
  endtask

  task automatic send_len(input logic [15:0] l);
    send_byte(l[15:8], 1'b0);
    send_byte(l[7:0], 1'b0);
  endtask

  // Payload from pl[]; gapk idle cycles between bytes, boot_req pulsed in one gap.
  task automatic send_payload(input int gapk);
    for (int i = 0; i < pl.size(); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gapk; g++) begin
          @(negedge clk);
          bus.rx_valid = 1'b0;
          boot_req     = (i == 2) && (g == 0);
        end
      end
      send_byte(pl[i], 1'b1);
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    exp_addr = '0;
    sum      = '0;
    n_writes = 0;
  endtask

  task automatic wait_end(input int lim);
    int n;
    n = 0;
    while (!(boot_done || boot_error) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 32'(boot_done | boot_error), 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_prog_we", 32'(bus.prog_we), 32'd0);
    check("rst_prog_addr", 32'(bus.prog_addr), 32'd0);
    check("rst_prog_wdata", 32'(bus.prog_wdata), 32'd0);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_boot_error", 32'(boot_error), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_bootstrapping", 32'(bootstrapping), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_LEN_HI));
  endtask

  initial begin
    logic [AW+7:0] exp_w;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // Write monitor: prog_we exactly one cycle after each payload accept, scored in order.
    fork
      forever begin
        @(negedge clk);
        if (arst_n) begin
          check("we_timing", 32'(bus.prog_we), 32'(we_exp));
          we_exp = 1'b0;
          if (bus.prog_we) begin
            n_writes++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("write_addr_data", 32'({bus.prog_addr, bus.prog_wdata}), 32'(exp_w));
          end
        end
      end
    join_none

    // Reset state, then AUTO_BOOT idle in LEN_HI never times out.
    repeat (2) @(negedge clk);
    check_reset_vals();
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    arst_n = 1'b1;
    repeat (3 * TO) @(negedge clk);
    check("autoboot_no_timeout", 32'(boot_error), 32'd0);
    check("autoboot_still_loading", 32'(bootstrapping), 32'd1);

    // Good image 00 03 12 34 56 9C.
    send_len(16'd3);
    pl = '{8'h12, 8'h34, 8'h56};
    send_payload(0);
    send_byte(8'h9C, 1'b0);
    end_stream();
    wait_end(20);
    check("good_done", 32'(boot_done), 32'd1);
    check("good_error", 32'(boot_error), 32'd0);
    check("good_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("good_bootstrapping", 32'(bootstrapping), 32'd0);
    check("good_writes", 32'(n_writes), 32'd3);
    check("good_addr_after", 32'(bus.prog_addr), 32'd3);
    check("good_rx_ready", 32'(bus.rx_ready), 32'd0);

    // boot_req with a coinciding byte: byte refused, load restarts cleanly.
    @(negedge clk);
    boot_req     = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    check("req_rx_ready_low", 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    boot_req     = 1'b0;
    bus.rx_valid = 1'b0;
    exp_addr = '0; sum = '0; n_writes = 0;
    check("req_state", 32'(dbg_state), 32'(ST_LEN_HI));
    check("req_done_cleared", 32'(boot_done), 32'd0);
    check("req_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("req_bootstrapping", 32'(bootstrapping), 32'd1);
    check("req_addr_zero", 32'(bus.prog_addr), 32'd0);

    // Bad checksum 00 02 AA 55 00 (required FF).
    send_len(16'd2);
    pl = '{8'hAA, 8'h55};
    send_payload(0);
    send_byte(8'h00, 1'b0);
    end_stream();
    wait_end(20);
    check("badck_error", 32'(boot_error), 32'd1);
    check("badck_done", 32'(boot_done), 32'd0);
    check("badck_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("badck_bootstrapping", 32'(bootstrapping), 32'd0);
    check("badck_writes", 32'(n_writes), 32'd2);
    repeat (2 * TO) @(negedge clk);
    check("badck_error_held", 32'(boot_error), 32'd1);

    // Zero length and over-capacity length both fail right after LEN_LO.
    start_load();
    send_len(16'h0000);
    end_stream();
    check("len0_state", 32'(dbg_state), 32'(ST_ERROR));
    check("len0_error", 32'(boot_error), 32'd1);
    check("len0_writes", 32'(n_writes), 32'd0);
    start_load();
    send_len(16'h1001);
    end_stream();
    check("lenbig_state", 32'(dbg_state), 32'(ST_ERROR));
    check("lenbig_error", 32'(boot_error), 32'd1);
    check("lenbig_writes", 32'(n_writes), 32'd0);

    // Stall after 00 04 11: timeout after TO idle cycles.
    start_load();
    send_len(16'd4);
    pl = '{8'h11};
    send_payload(0);
    end_stream();
    n = 0;
    while (!boot_error && n < 4 * TO) begin
      @(negedge clk);
      n++;
    end
    check("timeout_not_early", 32'(n >= TO), 32'd1);
    check("timeout_not_late", 32'(n <= TO + 1), 32'd1);
    check("timeout_error", 32'(boot_error), 32'd1);
    check("timeout_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("timeout_writes", 32'(n_writes), 32'd1);

    // Bubbles between payload bytes, plus an ignored boot_req mid-load.
    start_load();
    send_len(16'd4);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_payload(1);
    send_byte(sum, 1'b0);
    end_stream();
    wait_end(20);
    check("bubble_done", 32'(boot_done), 32'd1);
    check("bubble_error", 32'(boot_error), 32'd0);
    check("bubble_writes", 32'(n_writes), 32'd4);

    // Reset mid-load, then reload from address 0.
    start_load();
    send_len(16'd4);
    pl = '{8'hA1, 8'hA2};
    send_payload(0);
    end_stream();
    repeat (2) @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    check("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    arst_n = 1'b1;
    exp_addr = '0; sum = '0; n_writes = 0;
    send_len(16'd3);
    pl = '{8'hC0, 8'hC1, 8'hC2};
    send_payload(0);
    send_byte(sum, 1'b0);
    end_stream();
    wait_end(20);
    check("reload_done", 32'(boot_done), 32'd1);
    check("reload_writes", 32'(n_writes), 32'd3);

    // Full-capacity image: last write at 2^AW-1, address wraps to 0.
    start_load();
    pl.delete();
    for (int i = 0; i < (1 << AW); i++) pl.push_back(8'($urandom_range(0, 255)));
    send_len(16'(1 << AW));
    send_payload(0);
    send_byte(sum, 1'b0);
    end_stream();
    wait_end(20);
    check("full_done", 32'(boot_done), 32'd1);
    check("full_writes", 32'(n_writes), 32'(1 << AW));
    check("full_addr_wrap", 32'(bus.prog_addr), 32'd0);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
